// File: rtl/dcache_defs.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds address geometry, block width, FSM state encoding and the byte
// helpers. There is no logic here, so it adds no latency and takes no part in flow control.
package dcache_defs;

  localparam int ADDR_W      = 8;   // CPU byte address width
  localparam int DEF_INDEX_W = 3;   // default number of index bits
  localparam int OFFSET_W    = 2;   // one block = 4 bytes = one memory word
  localparam int BLOCK_W     = 32;
  localparam int MEM_ADDR_W  = ADDR_W - OFFSET_W;  // block address {tag, index}

  // Address field positions: {tag, index, offset}
  localparam int OFFSET_LSB = 0;
  localparam int INDEX_LSB  = OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_e;

  // Byte 0 sits in bits [7:0] of a block.
  function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                          input logic [OFFSET_W-1:0] off);
    get_byte = blk[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0] blk,
                                                  input logic [OFFSET_W-1:0] off,
                                                  input logic [7:0]          b);
    put_byte = blk;
    put_byte[{off, 3'b000} +: 8] = b;
  endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM: sequences write-back, block fetch and array update.
// Latency: a request lasts until MEM_BUSYWAIT is sampled low; UPDATE takes one cycle.
// Backpressure: it stalls the CPU through busywait until the access hits in IDLE.
// Ports: req/hit/dirty/tags/index/evict_blk in from the top; mem_* out to memory;
//        state/fill_blk out to the arrays; busywait out to the CPU.
module dcache_ctrl
  import dcache_defs::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  hit,
  input  logic                  dirty,
  input  logic [TAG_W-1:0]      stored_tag,
  input  logic [TAG_W-1:0]      addr_tag,
  input  logic [INDEX_W-1:0]    index,
  input  logic [BLOCK_W-1:0]    evict_blk,
  input  logic                  mem_busywait,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  output state_e                state,
  output logic [BLOCK_W-1:0]    fill_blk,
  output logic                  busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [BLOCK_W-1:0]    mem_writedata
);

  state_e                state_q, state_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [BLOCK_W-1:0]    fill_q, fill_d;

  // Memory request outputs are registered: they are set up on the edge that
  // enters WRITEBACK/FETCH and dropped on the edge that completes the request.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_d      = fill_q;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          if (dirty) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {stored_tag, index};
            mem_wdata_d = evict_blk;
          end else begin
            state_d    = FETCH;
            mem_read_d = 1'b1;
            mem_addr_d = {addr_tag, index};
          end
        end
      end
      WRITEBACK: begin
        if (!mem_busywait) begin
          state_d     = FETCH;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = {addr_tag, index};
        end
      end
      FETCH: begin
        if (!mem_busywait) begin
          state_d    = UPDATE;
          mem_read_d = 1'b0;
          fill_d     = mem_readdata;
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fill_q      <= fill_d;
    end
  end

  // Only an IDLE hit lets the CPU proceed; every other cycle with a request stalls.
  assign busywait      = req && !((state_q == IDLE) && hit);
  assign state         = state_q;
  assign fill_blk      = fill_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_addr_q;
  assign mem_writedata = mem_wdata_q;

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache between CPU and block memory.
// Latency: read hit is zero-stall; clean miss M+1 and dirty miss 2M+1 stall cycles after the detect cycle.
// Backpressure: BUSYWAIT holds the CPU; MEM_BUSYWAIT holds each block transfer.
// Ports: CLK, RESET (async, active low); CPU side READ/WRITE/ADDRESS/WRITEDATA -> READDATA/BUSYWAIT;
//        memory side MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA -> MEM_READDATA/MEM_BUSYWAIT.
module dcache_dm_wb
  import dcache_defs::*;
#(
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NUM_BLOCKS = 1 << INDEX_W;

  logic [NUM_BLOCKS-1:0]              valid_q, valid_d;
  logic [NUM_BLOCKS-1:0]              dirty_q, dirty_d;
  logic [NUM_BLOCKS-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] data_q, data_d;

  logic [OFFSET_W-1:0] addr_off;
  logic [INDEX_W-1:0]  addr_idx;
  logic [TAG_W-1:0]    addr_tag;
  logic                req;
  logic                hit;
  state_e              state;
  logic [BLOCK_W-1:0]  fill_blk;

  assign addr_off = ADDRESS[OFFSET_LSB +: OFFSET_W];
  assign addr_idx = ADDRESS[INDEX_LSB +: INDEX_W];
  assign addr_tag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign req      = READ || WRITE;
  assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign READDATA = get_byte(data_q[addr_idx], addr_off);

  dcache_ctrl #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_ctrl (
    .clk           (CLK),
    .rst_n         (RESET),
    .req           (req),
    .hit           (hit),
    .dirty         (dirty_q[addr_idx]),
    .stored_tag    (tag_q[addr_idx]),
    .addr_tag      (addr_tag),
    .index         (addr_idx),
    .evict_blk     (data_q[addr_idx]),
    .mem_busywait  (MEM_BUSYWAIT),
    .mem_readdata  (MEM_READDATA),
    .state         (state),
    .fill_blk      (fill_blk),
    .busywait      (BUSYWAIT),
    .mem_read      (MEM_READ),
    .mem_write     (MEM_WRITE),
    .mem_address   (MEM_ADDRESS),
    .mem_writedata (MEM_WRITEDATA)
  );

  // A store only lands on an IDLE hit; a simultaneous READ is ignored, so
  // READ+WRITE behaves as a plain store. After UPDATE the held access hits in IDLE.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (state == UPDATE) begin
      data_d[addr_idx]  = fill_blk;
      tag_d[addr_idx]   = addr_tag;
      valid_d[addr_idx] = 1'b1;
      dirty_d[addr_idx] = 1'b0;
    end else if ((state == IDLE) && hit && WRITE) begin
      data_d[addr_idx]  = put_byte(data_q[addr_idx], addr_off, WRITEDATA);
      dirty_d[addr_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Directed bench for dcache_dm_wb with a block memory of fixed latency M.
// A memory request is outstanding for M cycles; MEM_BUSYWAIT is low in the M-th.
// Stall count = BUSYWAIT-high cycles after the cycle in which the miss is first seen.
module tb_dcache_dm_wb;

  localparam int M     = 5;
  localparam int LIMIT = 100;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  dcache_dm_wb dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // ---------------- memory model ----------------
  logic [31:0] wr_mem [64];
  logic [63:0] wr_vld = '0;
  int          mem_cnt = 0;

  function automatic logic [31:0] init_word(input logic [5:0] a);
    case (a)
      6'h01:   init_word = 32'hDDCCBBAA;
      6'h09:   init_word = 32'h44332211;
      6'h20:   init_word = 32'h87654321;
      default: init_word = 32'h0;
    endcase
  endfunction

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt != M-1);
  assign MEM_READDATA = wr_vld[MEM_ADDRESS] ? wr_mem[MEM_ADDRESS] : init_word(MEM_ADDRESS);

  always @(posedge CLK) begin
    if (MEM_READ || MEM_WRITE) begin
      if (mem_cnt == M-1) begin
        mem_cnt <= 0;
        if (MEM_WRITE) begin
          wr_mem[MEM_ADDRESS] <= MEM_WRITEDATA;
          wr_vld[MEM_ADDRESS] <= 1'b1;
        end
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Results of the last access
  int          acc_busy;
  logic [7:0]  acc_rdata;
  logic        saw_rd, saw_wb;
  logic [5:0]  rd_addr, wb_addr;
  logic [31:0] wb_data;

  // Present one access at a negedge, hold it until BUSYWAIT drops, let the
  // hit edge pass, then release the request.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    #1;
    acc_busy = 0; saw_rd = 1'b0; saw_wb = 1'b0;
    rd_addr = '0; wb_addr = '0; wb_data = '0;
    while (BUSYWAIT && acc_busy < LIMIT) begin
      acc_busy++;
      @(negedge CLK); #1;
      if (MEM_WRITE) begin saw_wb = 1'b1; wb_addr = MEM_ADDRESS; wb_data = MEM_WRITEDATA; end
      if (MEM_READ)  begin saw_rd = 1'b1; rd_addr = MEM_ADDRESS; end
    end
    chk("access_done", {31'b0, acc_busy < LIMIT}, 32'd1);
    acc_rdata = READDATA;
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    #12;
    // Reset state
    chk("rst_mem_read",  {31'b0, MEM_READ},  32'd0);
    chk("rst_mem_write", {31'b0, MEM_WRITE}, 32'd0);
    chk("rst_mem_addr",  {26'b0, MEM_ADDRESS}, 32'd0);
    chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
    chk("rst_readdata",  {24'b0, READDATA}, 32'd0);
    chk("rst_busy_idle", {31'b0, BUSYWAIT}, 32'd0);
    READ = 1'b1; #1;
    chk("rst_busy_req",  {31'b0, BUSYWAIT}, 32'd1);
    READ = 1'b0;
    @(negedge CLK); RESET = 1'b1;

    // 1: clean read miss on 0x05 (tag 0, index 1, byte 1)
    access(1'b1, 1'b0, 8'h05, 8'h00);
    chk("miss1_fetch",   {31'b0, saw_rd}, 32'd1);
    chk("miss1_nowb",    {31'b0, saw_wb}, 32'd0);
    chk("miss1_maddr",   {26'b0, rd_addr}, 32'h01);
    chk("miss1_stall",   acc_busy - 1, M + 1);
    chk("miss1_rdata",   {24'b0, acc_rdata}, 32'hBB);

    // 2: read hit on 0x07
    access(1'b1, 1'b0, 8'h07, 8'h00);
    chk("hit_stall",     acc_busy, 32'd0);
    chk("hit_rdata",     {24'b0, acc_rdata}, 32'hDD);
    chk("hit_nofetch",   {31'b0, saw_rd}, 32'd0);

    // 3: write hit 0x5A to 0x06, read back
    access(1'b0, 1'b1, 8'h06, 8'h5A);
    chk("whit_stall",    acc_busy, 32'd0);
    access(1'b1, 1'b0, 8'h06, 8'h00);
    chk("whit_rdata",    {24'b0, acc_rdata}, 32'h5A);
    chk("whit_dirty",    {31'b0, dut.dirty_q[1]}, 32'd1);

    // 4: dirty miss on 0x25 (tag 1, index 1)
    access(1'b1, 1'b0, 8'h25, 8'h00);
    chk("dmiss_wb",      {31'b0, saw_wb}, 32'd1);
    chk("dmiss_wbaddr",  {26'b0, wb_addr}, 32'h01);
    chk("dmiss_wbdata",  wb_data, 32'hDD5ABBAA);
    chk("dmiss_fetch",   {26'b0, rd_addr}, 32'h09);
    chk("dmiss_stall",   acc_busy - 1, 2*M + 1);
    chk("dmiss_rdata",   {24'b0, acc_rdata}, 32'h22);
    chk("dmiss_memcopy", wr_mem[1], 32'hDD5ABBAA);

    // 5: clean-miss write 0xC3 to 0x80 (tag 4, index 0)
    access(1'b0, 1'b1, 8'h80, 8'hC3);
    chk("wmiss_nowb",    {31'b0, saw_wb}, 32'd0);
    chk("wmiss_maddr",   {26'b0, rd_addr}, 32'h20);
    chk("wmiss_stall",   acc_busy - 1, M + 1);
    chk("wmiss_dirty",   {31'b0, dut.dirty_q[0]}, 32'd1);
    access(1'b1, 1'b0, 8'h80, 8'h00);
    chk("wmiss_byte0",   {24'b0, acc_rdata}, 32'hC3);
    access(1'b1, 1'b0, 8'h81, 8'h00);
    chk("wmiss_byte1",   {24'b0, acc_rdata}, 32'h43);

    // 6: reset in the middle of a fetch for 0x05 (index 1 now holds tag 1, clean)
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h05;
    @(negedge CLK); @(negedge CLK); #1;
    chk("mid_fetch_rd",  {31'b0, MEM_READ}, 32'd1);
    RESET = 1'b0; #1;
    chk("rst_drop_rd",   {31'b0, MEM_READ}, 32'd0);
    chk("rst_state",     {30'b0, dut.u_ctrl.state_q}, 32'd0);
    READ = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    access(1'b1, 1'b0, 8'h05, 8'h00);
    chk("post_rst_miss", {31'b0, saw_rd}, 32'd1);
    chk("post_rst_stall", acc_busy - 1, M + 1);
    chk("post_rst_rdata", {24'b0, acc_rdata}, 32'hBB);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
